// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : Shared definitions for the sequential restoring divider:
//                controller state encoding and default operand width.
//  Contents    : DEFAULT_WIDTH - default operand/quotient/remainder width
//                state_t       - IDLE/ITER/FIN; encoding 2'd3 is illegal and
//                                recovers to IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/addsub_n.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_n
//  Description : N-bit combinational ripple-carry adder/subtractor.
//                b is inverted by sub and sub is the carry-in, so sub=1
//                computes a - b with cout=1 meaning a >= b (unsigned).
//  Ports       : a    [N-1:0] in  first operand
//                b    [N-1:0] in  second operand
//                sub          in  1 = subtract, 0 = add
//                sum  [N-1:0] out result
//                cout         out carry out of the top stage
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0]   w_carry;
  logic [N-1:0] w_b_eff;

  assign w_carry[0] = sub;

  for (genvar i = 0; i < N; i++) begin : g_stage
    assign w_b_eff[i]   = b[i] ^ sub;
    assign sum[i]       = a[i] ^ w_b_eff[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
  end

  assign cout = w_carry[N];

endmodule : addsub_n
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle unsigned restoring divider. One quotient bit is
//                resolved per cycle through a single shared (WIDTH+1)-bit
//                add/sub stage. Results are held until the next accepted
//                start; done is a one-cycle strobe.
//  Ports       : clk                      in  clock, rising edge
//                reset                    in  synchronous, active-high
//                start                    in  request, sampled only in IDLE
//                dividend    [WIDTH-1:0]  in  captured with start
//                divisor     [WIDTH-1:0]  in  captured with start
//                quotient    [WIDTH-1:0]  out result (all ones on /0)
//                remainder   [WIDTH-1:0]  out result (dividend on /0)
//                busy                     out operation in progress
//                done                     out one-cycle result strobe
//                div_by_zero              out last result had divisor 0
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH:0]   r_a;      // partial remainder
  logic [WIDTH-1:0] r_q;      // dividend in, quotient out
  logic [WIDTH-1:0] r_d;      // captured divisor
  logic [CNT_W-1:0] r_cnt;    // iterations left
  logic             r_zero;   // captured divisor was zero

  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_diff;
  logic             w_cout;
  logic             w_sub;

  // Shift the next dividend bit into the partial remainder.
  assign w_t   = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  // Only ITER consumes the stage result; outside it the mode is irrelevant.
  assign w_sub = (r_state == ITER);

  addsub_n #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a    (w_t),
    .b    ({1'b0, r_d}),
    .sub  (w_sub),
    .sum  (w_diff),
    .cout (w_cout)
  );

  // The top bit of A is never significant once stored: after a successful
  // subtract T < 2D keeps it zero, and a restore keeps T < 2^WIDTH there.
  logic w_unused_a_msb;
  assign w_unused_a_msb = r_a[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a         <= '0;
            r_q         <= dividend;
            r_d         <= divisor;
            r_cnt       <= CNT_W'(WIDTH);
            r_zero      <= (divisor == '0);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            r_state     <= (divisor == '0) ? FIN : ITER;
          end
        end

        ITER: begin
          // Carry out means T >= D: keep the difference, quotient bit 1.
          r_a   <= w_cout ? w_diff : w_t;
          r_q   <= {r_q[WIDTH-2:0], w_cout};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            busy    <= 1'b0;
            r_state <= FIN;
          end
        end

        FIN: begin
          if (busy) begin
            // Zero divisor arrives here straight from IDLE with busy still
            // set; spend one cycle dropping it so done lands two cycles
            // after acceptance.
            busy <= 1'b0;
          end else begin
            done    <= 1'b1;
            r_state <= IDLE;
            if (r_zero) begin
              quotient    <= '1;
              remainder   <= r_q;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= r_q;
              remainder   <= r_a[WIDTH-1:0];
            end
          end
        end

        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider (WIDTH=4). Expected
//                results come from plain integer division; latency, busy
//                length, strobe width, result holding and reset abort are
//                checked per operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int WIDTH = 4;
  localparam int CLK_PERIOD = 10;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] prev_q = '0;
  logic [WIDTH-1:0] prev_r = '0;
  time              last_done_time = 0;

  seq_divider #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Issue one division from IDLE and follow it to its done strobe.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit hold, input bit noise);
    logic [WIDTH-1:0] eq, er;
    bit               ez;
    int               lat, bsy, exp_lat, exp_bsy;
    if (b == 0) begin
      eq = '1; er = a; ez = 1'b1; exp_lat = 2; exp_bsy = 1;
    end else begin
      eq = WIDTH'(a / b); er = WIDTH'(a % b); ez = 1'b0;
      exp_lat = WIDTH + 1; exp_bsy = WIDTH;
    end

    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = hold;
    dividend = WIDTH'($urandom); divisor = WIDTH'($urandom);

    check("busy_after_accept", busy, 1);
    check("done_low_after_accept", done, 0);
    check("dbz_cleared_on_start", div_by_zero, 0);
    check("old_quotient_held", quotient, prev_q);
    check("old_remainder_held", remainder, prev_r);

    bsy = busy;
    lat = 0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      bsy += int'(busy);
    end
    if (noise) start = 1'b0;

    check("latency", lat, exp_lat);
    check("busy_cycles", bsy, exp_bsy);
    check("busy_low_at_done", busy, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    if (b != 0) check("identity", quotient * b + remainder, a);

    prev_q = eq;
    prev_r = er;
    last_done_time = $time;
  endtask

  // With start low, the block must stay quiet.
  task automatic idle_quiet(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      check("idle_no_done", done, 0);
      check("idle_no_busy", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t_prev;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    idle_quiet(2);

    // Basic 13/4.
    run_op(4'd13, 4'd4, 1'b0, 1'b0);
    idle_quiet(2);

    // Back-to-back: second start in the IDLE cycle right after done.
    run_op(4'd15, 4'd1, 1'b0, 1'b0);
    run_op(4'd7, 4'd9, 1'b0, 1'b0);
    start = 1'b0;
    idle_quiet(2);

    // Divide by zero, then a normal op clears the flag.
    run_op(4'd9, 4'd0, 1'b0, 1'b0);
    idle_quiet(1);
    run_op(4'd6, 4'd3, 1'b0, 1'b0);
    idle_quiet(1);

    // Start held high: one result every WIDTH+2 cycles.
    run_op(4'd0, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      t_prev = last_done_time;
      run_op(4'd0, 4'd5, 1'b1, 1'b0);
      check("held_start_period", (last_done_time - t_prev) / CLK_PERIOD, WIDTH + 2);
    end
    start = 1'b0;
    idle_quiet(2);

    // Start pulses during ITER/FIN are ignored.
    for (int i = 0; i < 4; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom_range(1, 15)), 1'b0, 1'b1);
      idle_quiet(2);
    end

    // Reset in the second ITER cycle of 14/3 aborts it.
    run_op(4'd13, 4'd4, 1'b0, 1'b0);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", div_by_zero, 0);
    reset = 1'b0;
    prev_q = '0;
    prev_r = '0;
    idle_quiet(WIDTH + 2);
    run_op(4'd14, 4'd3, 1'b0, 1'b0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(WIDTH'(a), WIDTH'(b), 1'b0, 1'b0);
      end
    end
    idle_quiet(1);

    // Random operations, some with start noise and some back-to-back.
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_quiet(1);
    end
    start = 1'b0;
    idle_quiet(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_divider
`default_nettype wire
